// File: rtl/fw_rule_matcher_pkg.sv
// Shared types for the firewall matcher and the packet dispatcher.
// Header, FIFO entry, tagged verdict and rule layouts.
package fw_pkg;
  localparam int INDEX_W = 4;

  typedef struct packed {
    logic [7:0]  protocol;
    logic [31:0] srcip;
    logic [31:0] dstip;
    logic [15:0] srcport;
    logic [15:0] dstport;
  } header_t;

  typedef struct packed {
    logic               id;
    logic [INDEX_W-1:0] tag;
    header_t            header;
  } fifo_struct_t;

  typedef struct packed {
    logic               id;
    logic [INDEX_W-1:0] tag;
    logic               res;
  } tagged_index_t;

  typedef struct packed {
    logic        valid;
    logic        permit;
    logic        proto_any;
    logic [7:0]  protocol;
    logic [31:0] srcip;
    logic [31:0] src_mask;
    logic [31:0] dstip;
    logic [31:0] dst_mask;
    logic [15:0] dport_lo;
    logic [15:0] dport_hi;
  } fw_rule_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESULT} fw_state_e;
endpackage

// File: rtl/fw_rule_matcher_if.sv
// Header-in / verdict-out / rule-config handshakes of the firewall matcher.
// master = dispatcher/config side, slave = matcher.
interface fw_rule_matcher_if import fw_pkg::*; #(parameter int RULE_W = 3) ();
  logic                in_valid;
  logic                in_ready;
  fifo_struct_t        in_entry;
  logic                out_valid;
  logic                out_ready;
  tagged_index_t       out_result;
  logic                out_hit;
  logic [RULE_W-1:0]   out_rule;
  logic                cfg_we;
  logic [RULE_W-1:0]   cfg_addr;
  fw_rule_t            cfg_rule;
  logic                cfg_ready;

  modport master (
    output in_valid, in_entry, out_ready, cfg_we, cfg_addr, cfg_rule,
    input  in_ready, out_valid, out_result, out_hit, out_rule, cfg_ready
  );
  modport slave (
    input  in_valid, in_entry, out_ready, cfg_we, cfg_addr, cfg_rule,
    output in_ready, out_valid, out_result, out_hit, out_rule, cfg_ready
  );
endinterface

// File: rtl/fw_rule_matcher_compare.sv
// Combinational test of one header against one rule; all terms ANDed.
// An inverted port range (lo > hi) can never satisfy both bounds.
module fw_rule_compare import fw_pkg::*; (
  input  header_t  i_hdr,
  input  fw_rule_t i_rule,
  output logic     o_match
);
  logic w_proto, w_src, w_dst, w_port;
  logic w_unused_srcport;

  assign w_proto = i_rule.proto_any || (i_hdr.protocol == i_rule.protocol);
  assign w_src   = (i_hdr.srcip & i_rule.src_mask) == (i_rule.srcip & i_rule.src_mask);
  assign w_dst   = (i_hdr.dstip & i_rule.dst_mask) == (i_rule.dstip & i_rule.dst_mask);
  assign w_port  = (i_hdr.dstport >= i_rule.dport_lo) && (i_hdr.dstport <= i_rule.dport_hi);
  assign o_match = i_rule.valid && w_proto && w_src && w_dst && w_port;

  assign w_unused_srcport = ^i_hdr.srcport;
endmodule

// File: rtl/fw_rule_matcher.sv
// Firewall classifier: scans the rule table one rule per cycle for each header,
// first valid match decides, otherwise DEFAULT_PERMIT. One entry in flight.
module fw_rule_matcher import fw_pkg::*; #(
  parameter int NUM_RULES      = 8,
  parameter int RULE_W         = $clog2(NUM_RULES),
  parameter bit DEFAULT_PERMIT = 1'b0
) (
  input  logic             eth_mii_rx_clk,
  input  logic             eth_mii_rx_rstn,
  fw_rule_matcher_if.slave bus,
  output logic [15:0]      permit_cnt,
  output logic [15:0]      drop_cnt
);
  fw_state_e     r_state;
  fw_rule_t      r_rules [NUM_RULES];
  fifo_struct_t  r_entry;
  logic [RULE_W-1:0] r_k, r_rule;
  logic          r_in_ready, r_out_valid, r_hit;
  tagged_index_t r_result;
  logic [15:0]   r_permit, r_drop;
  fw_rule_t      w_rule;
  logic          w_match;

  assign w_rule = r_rules[r_k];

  fw_rule_compare u_cmp (.i_hdr(r_entry.header), .i_rule(w_rule), .o_match(w_match));

  // Writes only land in IDLE, so an accept in the same cycle scans the new rule.
  always_ff @(posedge eth_mii_rx_clk or negedge eth_mii_rx_rstn) begin
    if (!eth_mii_rx_rstn) begin
      for (int i = 0; i < NUM_RULES; i++) r_rules[i] <= '0;
    end else if (bus.cfg_we && r_in_ready) begin
      r_rules[bus.cfg_addr] <= bus.cfg_rule;
    end
  end

  always_ff @(posedge eth_mii_rx_clk or negedge eth_mii_rx_rstn) begin
    if (!eth_mii_rx_rstn) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_hit       <= 1'b0;
      r_rule      <= '0;
      r_k         <= '0;
      r_entry     <= '0;
      r_permit    <= '0;
      r_drop      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_entry    <= bus.in_entry;
          r_k        <= '0;
          r_in_ready <= 1'b0;
          r_state    <= ST_SCAN;
        end
        ST_SCAN: begin
          if (w_match) begin
            r_result    <= '{id: r_entry.id, tag: r_entry.tag, res: w_rule.permit};
            r_hit       <= 1'b1;
            r_rule      <= r_k;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else if (r_k == RULE_W'(NUM_RULES - 1)) begin
            r_result    <= '{id: r_entry.id, tag: r_entry.tag, res: DEFAULT_PERMIT};
            r_hit       <= 1'b0;
            r_rule      <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_RESULT: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
          if (r_result.res) r_permit <= r_permit + 16'd1;
          else              r_drop   <= r_drop + 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.cfg_ready  = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_result;
  assign bus.out_hit    = r_hit;
  assign bus.out_rule   = r_rule;
  assign permit_cnt     = r_permit;
  assign drop_cnt       = r_drop;
endmodule

// File: tb/tb_fw_rule_matcher.sv
// Bench for fw_rule_matcher: directed cases plus randomized headers/rules,
// checked against a first-match reference over a shadow rule table.
module tb_fw_rule_matcher;
  import fw_pkg::*;
  localparam int NR = 8;
  localparam int RW = 3;
  localparam bit DEFP = 1'b0;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic [15:0] permit_cnt, drop_cnt;

  fw_rule_matcher_if #(.RULE_W(RW)) bus ();

  fw_rule_matcher #(.NUM_RULES(NR), .RULE_W(RW), .DEFAULT_PERMIT(DEFP)) dut (
    .eth_mii_rx_clk(gclk), .eth_mii_rx_rstn(grst_n), .bus(bus),
    .permit_cnt(permit_cnt), .drop_cnt(drop_cnt));

  always #5 gclk = ~gclk;

  fw_rule_t     m_rules [NR];
  logic [15:0]  m_perm, m_drop;
  int           n_chk = 0, n_pass = 0;
  bit           e_res, e_hit;
  int           e_rule, e_lat;
  fifo_struct_t e_ent;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic fw_rule_t mk_rule(bit v, bit p, bit pa, logic [7:0] pr,
      logic [31:0] s, logic [31:0] sm, logic [31:0] d, logic [31:0] dm,
      logic [15:0] lo, logic [15:0] hi);
    return {v, p, pa, pr, s, sm, d, dm, lo, hi};
  endfunction

  function automatic fifo_struct_t mk_hdr(bit id, logic [3:0] tag, logic [7:0] pr,
      logic [31:0] s, logic [31:0] d, logic [15:0] sp, logic [15:0] dp);
    return {id, tag, pr, s, d, sp, dp};
  endfunction

  // Reference: a rule rejects on any differing bit under a mask or an out-of-range port.
  function automatic bit model_match(header_t h, fw_rule_t r);
    if (!r.valid) return 1'b0;
    if (!r.proto_any && h.protocol != r.protocol) return 1'b0;
    if (((h.srcip ^ r.srcip) & r.src_mask) != 32'd0) return 1'b0;
    if (((h.dstip ^ r.dstip) & r.dst_mask) != 32'd0) return 1'b0;
    if (int'(h.dstport) < int'(r.dport_lo) || int'(h.dstport) > int'(r.dport_hi)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic predict(fifo_struct_t e);
    e_ent = e; e_hit = 0; e_res = DEFP; e_rule = 0; e_lat = NR;
    for (int i = 0; i < NR; i++)
      if (model_match(e.header, m_rules[i])) begin
        e_hit = 1; e_res = m_rules[i].permit; e_rule = i; e_lat = i + 1;
        break;
      end
  endtask

  task automatic accept(fifo_struct_t e);
    @(negedge gclk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_entry = e;
    predict(e);
    @(posedge gclk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(int hold, bit pend);
    int lat = 0;
    tagged_index_t exp_out;
    while (!bus.out_valid && lat < 64) begin @(posedge gclk); #1; lat++; end
    chk("latency", lat, e_lat);
    exp_out = {e_ent.id, e_ent.tag, e_res};
    chk("out_valid", bus.out_valid, 1);
    chk("out_result", bus.out_result, exp_out);
    chk("out_hit", bus.out_hit, e_hit);
    chk("out_rule", bus.out_rule, e_rule);
    for (int c = 0; c < hold; c++) begin
      if (pend) begin bus.in_valid = 1'b1; bus.in_entry = ~e_ent; end
      @(posedge gclk); #1;
      chk("hold_result", bus.out_result, exp_out);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_cnt", {permit_cnt, drop_cnt}, {m_perm, m_drop});
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge gclk); #1;
    bus.out_ready = 1'b0;
    if (e_res) m_perm++; else m_drop++;
    chk("out_valid_clr", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    chk("permit_cnt", permit_cnt, m_perm);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic send(fifo_struct_t e, int hold, bit pend);
    accept(e);
    collect(hold, pend);
  endtask

  task automatic cfg_write(int a, fw_rule_t r);
    int w = 0;
    @(negedge gclk);
    bus.cfg_we = 1'b1; bus.cfg_addr = RW'(a); bus.cfg_rule = r;
    while (!bus.cfg_ready && w < 64) begin @(negedge gclk); w++; end
    chk("cfg_wait", w < 64, 1);
    @(posedge gclk); #1;
    bus.cfg_we = 1'b0;
    m_rules[a] = r;
  endtask

  function automatic logic [31:0] rnd_mask();
    case ($urandom_range(0, 2))
      0:       return 32'h0;
      1:       return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic fw_rule_t rnd_rule();
    return mk_rule($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
      $urandom_range(0, 1) ? 8'd6 : 8'd17,
      {24'h0A0000, 8'($urandom_range(0, 3))}, rnd_mask(),
      {16'h0A00, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 3))}, rnd_mask(),
      16'($urandom_range(75, 85)), 16'($urandom_range(75, 90)));
  endfunction

  function automatic fifo_struct_t rnd_hdr();
    return mk_hdr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
      $urandom_range(0, 1) ? 8'd6 : 8'd17,
      {24'h0A0000, 8'($urandom_range(0, 3))},
      {16'h0A00, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 3))},
      16'($urandom), 16'($urandom_range(70, 95)));
  endfunction

  initial begin
    fifo_struct_t h_a, h_b;
    fw_rule_t     r5;
    bus.in_valid = 0; bus.in_entry = '0; bus.out_ready = 0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_rule = '0;
    for (int i = 0; i < NR; i++) m_rules[i] = '0;
    m_perm = 0; m_drop = 0;

    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_hit", bus.out_hit, 0);
    chk("rst_out_rule", bus.out_rule, 0);
    chk("rst_cnts", {permit_cnt, drop_cnt}, 0);
    @(negedge gclk); grst_n = 1'b1;

    h_a = mk_hdr(1'b0, 4'd3, 8'd6, 32'h0A00_0009, 32'h0A00_0001, 16'd1234, 16'd80);
    h_b = mk_hdr(1'b1, 4'd9, 8'd17, 32'h0A00_0002, 32'hC0A8_0101, 16'd5000, 16'd53);

    send(h_a, 0, 0);  // empty table: default drop after NR cycles
    cfg_write(2, mk_rule(1, 1, 0, 8'd6, 32'h0, 32'h0, 32'h0A00_0000, 32'hFFFF_FF00, 16'd80, 16'd80));
    send(h_a, 5, 1);  // hit rule 2, held 5 cycles with a pending entry
    cfg_write(0, mk_rule(1, 0, 1, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0, 16'hFFFF));
    cfg_write(1, mk_rule(1, 1, 0, 8'd6, 32'h0A00_0009, 32'hFFFF_FFFF, 32'h0A00_0001, 32'hFFFF_FFFF, 16'd80, 16'd80));
    send(h_a, 0, 0);  // rule 0 wins over rule 1

    // Reset while the scan is on rule 4
    cfg_write(0, '0);
    accept(h_b);
    repeat (4) @(posedge gclk);
    #1 grst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_cnts", {permit_cnt, drop_cnt}, 0);
    for (int i = 0; i < NR; i++) m_rules[i] = '0;
    m_perm = 0; m_drop = 0;
    @(negedge gclk); grst_n = 1'b1;
    send(h_a, 0, 0);  // rules gone: default again

    // Write held through a scan must not land until IDLE
    r5 = mk_rule(1, 1, 0, 8'd6, 32'h0, 32'h0, 32'h0A00_0001, 32'hFFFF_FFFF, 16'd0, 16'd100);
    accept(h_a);
    @(negedge gclk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd5; bus.cfg_rule = r5;
    #1 chk("cfg_ready_scan", bus.cfg_ready, 0);
    collect(2, 0);
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    @(posedge gclk); #1;
    bus.cfg_we = 1'b0;
    m_rules[5] = r5;
    send(h_a, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if (n % 8 == 0) cfg_write($urandom_range(0, NR - 1), rnd_rule());
      send(rnd_hdr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
